// File: rtl/video_view_controller.sv
// Camera-path view controller: frame-synchronous channel select driven by a
// debounced button, detector hysteresis for the stop signal, and a frame watchdog.

module video_view_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic             btn_meta;
    logic             btn_sync;
    logic             level;
    logic [DEB_W-1:0] stab_cnt;
    logic             accept;

    // Counting only while the synced level differs from the accepted one means
    // any bounce back to the accepted level restarts the count.
    assign accept = (btn_sync != level) && (stab_cnt == DEB_W'(DEB_CYCLES - 1));
    assign press  = accept && !btn_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b1;
            btn_sync <= 1'b1;
            level    <= 1'b1;
            stab_cnt <= '0;
        end else begin
            btn_meta <= btn_n;
            btn_sync <= btn_meta;
            if (btn_sync == level) begin
                stab_cnt <= '0;
            end else if (accept) begin
                level    <= btn_sync;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + DEB_W'(1);
            end
        end
    end
endmodule

module video_view_hyst #(
    parameter int ON_FRAMES  = 3,
    parameter int OFF_FRAMES = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic det_valid,
    input  logic det_flag,
    output logic filt_stop
);
    localparam int ON_W  = $clog2(ON_FRAMES + 1);
    localparam int OFF_W = $clog2(OFF_FRAMES + 1);

    logic [ON_W-1:0]  pos_cnt, pos_nxt;
    logic [OFF_W-1:0] neg_cnt, neg_nxt;

    always_comb begin
        pos_nxt = pos_cnt;
        neg_nxt = neg_cnt;
        if (det_valid) begin
            if (det_flag) begin
                pos_nxt = (pos_cnt == ON_W'(ON_FRAMES)) ? pos_cnt : pos_cnt + ON_W'(1);
                neg_nxt = '0;
            end else begin
                neg_nxt = (neg_cnt == OFF_W'(OFF_FRAMES)) ? neg_cnt : neg_cnt + OFF_W'(1);
                pos_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_cnt   <= '0;
            neg_cnt   <= '0;
            filt_stop <= 1'b0;
        end else begin
            pos_cnt <= pos_nxt;
            neg_cnt <= neg_nxt;
            if (det_valid && det_flag && pos_nxt == ON_W'(ON_FRAMES))
                filt_stop <= 1'b1;
            else if (det_valid && !det_flag && neg_nxt == OFF_W'(OFF_FRAMES))
                filt_stop <= 1'b0;
        end
    end
endmodule

module video_view_controller #(
    parameter int NUM_CH      = 4,
    parameter int PIX_W       = 12,
    parameter int CNT_W       = 8,
    parameter int DEB_CYCLES  = 500000,
    parameter int ON_FRAMES   = 3,
    parameter int OFF_FRAMES  = 5,
    parameter int TIMEOUT_CYC = 2000000,
    localparam int SEL_W      = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pix_valid,
    input  logic                    sof,
    input  logic [NUM_CH*PIX_W-1:0] ch_data,
    input  logic                    btn_n,
    input  logic                    det_valid,
    input  logic                    det_flag,
    input  logic [CNT_W-1:0]        det_count,
    output logic [PIX_W-1:0]        out_pixel,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        active_sel,
    output logic [SEL_W-1:0]        pending_sel,
    output logic [CNT_W-1:0]        count_hold,
    output logic                    stop_out,
    output logic                    stale
);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [NUM_CH-1:0][PIX_W-1:0] ch;
    logic                         press;
    logic                         filt_stop;
    logic [SEL_W-1:0]             act_nxt;
    logic [WD_W-1:0]              wd_cnt;

    assign ch = ch_data;

    video_view_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_n),
        .press (press)
    );

    video_view_hyst #(.ON_FRAMES(ON_FRAMES), .OFF_FRAMES(OFF_FRAMES)) u_hyst (
        .clk       (clk),
        .rst_n     (rst_n),
        .det_valid (det_valid),
        .det_flag  (det_flag),
        .filt_stop (filt_stop)
    );

    // sof takes the pre-press pending value; the first pixel of the frame already uses it.
    assign act_nxt = sof ? pending_sel : active_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_sel  <= '0;
            pending_sel <= '0;
        end else begin
            active_sel <= act_nxt;
            if (press)
                pending_sel <= (pending_sel == SEL_W'(NUM_CH - 1)) ? '0 : pending_sel + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pixel <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= pix_valid;
            if (pix_valid)
                out_pixel <= ch[act_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_hold <= '0;
        else if (det_valid)
            count_hold <= det_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt <= '0;
        else if (sof)
            wd_cnt <= '0;
        else if (wd_cnt != WD_W'(TIMEOUT_CYC))
            wd_cnt <= wd_cnt + WD_W'(1);
    end

    // Stale forces stop without touching the hysteresis state.
    assign stale    = (wd_cnt == WD_W'(TIMEOUT_CYC));
    assign stop_out = filt_stop | stale;
endmodule

// File: doc/video_view_controller.md
Name: video_view_controller

Overview:
- Parametrised successor to the board-level view/detection glue in the camera path.
- Selects one of NUM_CH pixel streams (raw camera, grayscale, edge map, and so on) for the VGA driver; channel switches happen only on frame boundaries.
- Debounces the channel-select button.
- Applies frame-count hysteresis to the zebra detector's per-frame result to produce a stable stop signal.
- Holds the last blob count for the HEX display and asserts a fail-safe stop when frames stop arriving.

Parameters:
- NUM_CH, 4: number of input pixel channels (2..8).
- PIX_W, 12: pixel width per channel (RGB444).
- CNT_W, 8: blob count width.
- DEB_CYCLES, 500000: cycles a button level must be stable to count as a press.
- ON_FRAMES, 3: consecutive positive detections required to assert stop.
- OFF_FRAMES, 5: consecutive negative detections required to release stop.
- TIMEOUT_CYC, 2000000: cycles without sof before the stream is declared stale.

Ports:
- clk, in, 1: video clock.
- rst_n, in, 1: reset, asynchronous, active-low; clock clk.
- pix_valid, in, 1: input pixel valid; same qualifier for all channels.
- sof, in, 1: single-cycle start-of-frame pulse, coincident with the first pix_valid of a frame.
- ch_data, in, NUM_CH*PIX_W: packed channels; channel i occupies bits [i*PIX_W +: PIX_W].
- btn_n, in, 1: raw asynchronous push-button, active-low.
- det_valid, in, 1: single-cycle pulse, one per frame, from the detector.
- det_flag, in, 1: detection result; sampled only when det_valid=1.
- det_count, in, CNT_W: blob count; sampled only when det_valid=1.
- out_pixel, out, PIX_W: selected pixel, registered.
- out_valid, out, 1: registered copy of pix_valid.
- active_sel, out, clog2(NUM_CH): channel currently driving out_pixel.
- pending_sel, out, clog2(NUM_CH): channel to be applied at the next sof.
- count_hold, out, CNT_W: last sampled det_count.
- stop_out, out, 1: hysteresis-filtered stop, OR-ed with stale.
- stale, out, 1: no sof seen for TIMEOUT_CYC cycles.

Behaviour:
- Reset values: out_pixel=0, out_valid=0, active_sel=0, pending_sel=0, count_hold=0, stop_out=0, stale=0. All internal counters cleared; button state is "released". Reset asserted mid-frame takes effect immediately (asynchronous). After release, outputs follow the rules below from the next edge.
- Button path:
  - btn_n passes through a 2-FF synchroniser, then a stability counter. The counter restarts on any change of the synchronised level.
  - A new level is accepted when it has been stable for DEB_CYCLES cycles.
  - An accepted high-to-low transition is a press event. A press increments pending_sel modulo NUM_CH (NUM_CH-1 wraps to 0).
  - A held button produces exactly one press.
- Frame-synchronous switch:
  - On a cycle with sof=1, active_sel <= pending_sel, using the value of pending_sel before any same-cycle press update.
  - A press coincident with sof is therefore applied at the following sof.
  - active_sel never changes on a cycle without sof.
- Pixel path, 1-cycle latency:
  - out_valid <= pix_valid.
  - out_pixel <= channel selected by the post-update active_sel. The first pixel of a new frame is therefore already taken from the new channel.
  - out_pixel holds its value when pix_valid=0.
- Detection hysteresis:
  - Two saturating counters, pos_cnt and neg_cnt, update only when det_valid=1.
  - det_flag=1: pos_cnt increments (saturating at ON_FRAMES) and neg_cnt clears.
  - det_flag=0: neg_cnt increments (saturating at OFF_FRAMES) and pos_cnt clears.
  - The filtered stop sets on the det_valid cycle on which pos_cnt reaches ON_FRAMES, and becomes visible on stop_out the next cycle.
  - The filtered stop clears when neg_cnt reaches OFF_FRAMES, with the same timing.
  - count_hold <= det_count on every det_valid, with 1-cycle latency.
- Watchdog:
  - A cycle counter clears on sof and saturates at TIMEOUT_CYC.
  - stale=1 while the counter equals TIMEOUT_CYC.
  - stale clears the cycle after the next sof.
  - stop_out = filtered_stop | stale. Stale forces stop (fail-safe) but does not modify the hysteresis counters.
- Simultaneous det_valid and sof: both are processed independently in the same cycle.

Test Plan:
- Reset then idle, DEB_CYCLES=4 for simulation: all outputs 0; stale rises after exactly TIMEOUT_CYC cycles without sof.
- btn_n low for 10 cycles with a 2-cycle glitch at the start: exactly one press; pending_sel 0->1; active_sel stays 0 until the next sof, then 1; the first post-sof out_pixel equals ch_data channel 1.
- NUM_CH=4, four presses: pending_sel steps 1,2,3,0 (wrap). A press on the same cycle as sof leaves active_sel at the old pending_sel value.
- det_valid sequence with flags 1,1,0,1,1,1: stop_out rises one cycle after the 6th pulse, not after the 2nd. count_hold tracks each sampled det_count (for example 7, 9, 0, 12, 12, 13).
- After stop is asserted, flags 0,0,0,0,1,0,0,0,0,0: stop_out stays 1 through the 1 (the 1 resets neg_cnt) and clears after the 5th consecutive 0.
- stale asserted while filtered stop=0: stop_out=1. Drive sof: stale and stop_out clear on the next cycle. Assert rst_n low mid-frame: all outputs 0 asynchronously.
